// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle control unit: state codes, opcodes,
// ALU/mux encodings and the control vector produced by the output decoder.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH = 4'd0,
        S_DEC   = 4'd1,
        S_MADDR = 4'd2,
        S_MRD   = 4'd3,
        S_MWB   = 4'd4,
        S_MWR   = 4'd5,
        S_REXE  = 4'd6,
        S_RWB   = 4'd7,
        S_BR    = 4'd8,
        S_IEXE  = 4'd9,
        S_IWB   = 4'd10,
        S_JMP   = 4'd11,
        S_HALT  = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // ALU operation codes, shared with the ALU control block.
    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Ungated control vector for one state. ir_write/pc_write in FETCH and
    // done in MWR are qualified by the memory-ready handshake in the top.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ior_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
        logic       done;
    } ctrl_t;

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Purely combinational map from FSM state to the raw control vector.
module mc_ctrl_outdec
    import mc_ctrl_pkg::*;
(
    input  state_t state,
    output ctrl_t  ctrl
);

    // Moore decode: everything defaults to 0, each state sets only its own fields.
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.ir_write  = 1'b1;
                ctrl.pc_write  = 1'b1;
            end
            S_DEC: begin
                ctrl.alu_src_b = SRCB_IMM_SH;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.ior_d    = 1'b1;
            end
            S_MWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.done       = 1'b1;
            end
            S_MWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.ior_d     = 1'b1;
                ctrl.done      = 1'b1;
            end
            S_REXE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_RT;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_RWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
                ctrl.done      = 1'b1;
            end
            S_BR: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_RT;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.done          = 1'b1;
            end
            S_IEXE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            S_IWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.done      = 1'b1;
            end
            S_JMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
                ctrl.done      = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle control FSM: sequences the shared ALU, unified memory port and
// register file over 3-5 cycles per instruction.
//
// Memory handshake: FETCH, MRD and MWR hold their request until the cycle in
// which mem_ready_i=1; that cycle completes the access and the FSM advances
// on the following edge. mem_ready_i is ignored in every other state.
module mc_control_unit #(
    parameter int ILLEGAL_TRAP = 0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [5:0] instr_op_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic       PCWrite_o,
    output logic       PCWriteCond_o,
    output logic       IorD_o,
    output logic       MemRead_o,
    output logic       MemWrite_o,
    output logic       IRWrite_o,
    output logic       MemtoReg_o,
    output logic       RegDst_o,
    output logic       RegWrite_o,
    output logic       ALUSrcA_o,
    output logic [1:0] ALUSrcB_o,
    output logic [2:0] ALU_op_o,
    output logic [1:0] PCSource_o,
    output logic       instr_done_o,
    output logic       illegal_o,
    output logic [3:0] state_o
);
    import mc_ctrl_pkg::*;

    state_t state;
    state_t next_state;
    state_t dec_state;
    ctrl_t  ctrl;
    ctrl_t  out;
    logic   op_legal;

    // The zero flag gates the PC load inside the datapath; the FSM itself
    // never branches on it.
    logic unused_zero;
    assign unused_zero = zero_i;

    // State register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= S_FETCH;
        else       state <= next_state;
    end

    // Next-state selection, including opcode dispatch out of DEC.
    always_comb begin
        next_state = state;
        op_legal   = 1'b1;
        case (state)
            S_FETCH: next_state = mem_ready_i ? S_DEC : S_FETCH;
            S_DEC: begin
                case (instr_op_i)
                    OP_LW, OP_SW: next_state = S_MADDR;
                    OP_RTYPE:     next_state = S_REXE;
                    OP_BEQ:       next_state = S_BR;
                    OP_ADDI:      next_state = S_IEXE;
                    OP_J:         next_state = S_JMP;
                    default: begin
                        op_legal   = 1'b0;
                        next_state = (ILLEGAL_TRAP != 0) ? S_HALT : S_FETCH;
                    end
                endcase
            end
            S_MADDR: next_state = (instr_op_i == OP_SW) ? S_MWR : S_MRD;
            S_MRD:   next_state = mem_ready_i ? S_MWB : S_MRD;
            S_MWB:   next_state = S_FETCH;
            S_MWR:   next_state = mem_ready_i ? S_FETCH : S_MWR;
            S_REXE:  next_state = S_RWB;
            S_RWB:   next_state = S_FETCH;
            S_BR:    next_state = S_FETCH;
            S_IEXE:  next_state = S_IWB;
            S_IWB:   next_state = S_FETCH;
            S_JMP:   next_state = S_FETCH;
            S_HALT:  next_state = S_HALT;
            default: next_state = S_FETCH;
        endcase
    end

    // While reset is held the mux selects show their FETCH values.
    assign dec_state = rst_i ? S_FETCH : state;

    mc_ctrl_outdec u_outdec (
        .state (dec_state),
        .ctrl  (ctrl)
    );

    // Handshake qualification and reset masking of enables and pulses.
    always_comb begin
        out = ctrl;
        if (dec_state == S_FETCH) begin
            out.ir_write = ctrl.ir_write & mem_ready_i;
            out.pc_write = ctrl.pc_write & mem_ready_i;
        end
        if (dec_state == S_MWR) begin
            out.done = ctrl.done & mem_ready_i;
        end
        if (rst_i) begin
            out.pc_write      = 1'b0;
            out.pc_write_cond = 1'b0;
            out.ir_write      = 1'b0;
            out.mem_read      = 1'b0;
            out.mem_write     = 1'b0;
            out.reg_write     = 1'b0;
            out.done          = 1'b0;
        end
    end

    assign PCWrite_o     = out.pc_write;
    assign PCWriteCond_o = out.pc_write_cond;
    assign IorD_o        = out.ior_d;
    assign MemRead_o     = out.mem_read;
    assign MemWrite_o    = out.mem_write;
    assign IRWrite_o     = out.ir_write;
    assign MemtoReg_o    = out.mem_to_reg;
    assign RegDst_o      = out.reg_dst;
    assign RegWrite_o    = out.reg_write;
    assign ALUSrcA_o     = out.alu_src_a;
    assign ALUSrcB_o     = out.alu_src_b;
    assign ALU_op_o      = out.alu_op;
    assign PCSource_o    = out.pc_source;
    assign instr_done_o  = out.done;
    assign illegal_o     = (dec_state == S_DEC) && !op_legal && !rst_i;
    assign state_o       = state;

endmodule

// File: tb/tb_mc_control_unit.sv
// Bench for mc_control_unit: a path-table reference model of each opcode's
// state walk plus a per-state table of expected control outputs.
module tb_mc_control_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       zero;
    logic [5:0] op;
    logic       rdy;

    // DUT with ILLEGAL_TRAP=0
    logic       pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, srca, done, ill;
    logic [1:0] srcb, pcs;
    logic [2:0] aop;
    logic [3:0] st0;
    // DUT with ILLEGAL_TRAP=1
    logic       h_pcw, h_pcwc, h_iord, h_mr, h_mw, h_irw, h_m2r, h_rdst, h_rw, h_srca, h_done, h_ill;
    logic [1:0] h_srcb, h_pcs;
    logic [2:0] h_aop;
    logic [3:0] st1;

    logic [18:0] obs0, obs1;
    assign obs0 = {pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, srca, srcb, aop, pcs, done, ill};
    assign obs1 = {h_pcw, h_pcwc, h_iord, h_mr, h_mw, h_irw, h_m2r, h_rdst, h_rw, h_srca,
                   h_srcb, h_aop, h_pcs, h_done, h_ill};

    int total = 0;
    int bad   = 0;
    int path[$];

    // clock
    always #5 clk = ~clk;

    mc_control_unit #(.ILLEGAL_TRAP(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .instr_op_i(op), .zero_i(zero), .mem_ready_i(rdy),
        .PCWrite_o(pcw), .PCWriteCond_o(pcwc), .IorD_o(iord), .MemRead_o(mr),
        .MemWrite_o(mw), .IRWrite_o(irw), .MemtoReg_o(m2r), .RegDst_o(rdst),
        .RegWrite_o(rw), .ALUSrcA_o(srca), .ALUSrcB_o(srcb), .ALU_op_o(aop),
        .PCSource_o(pcs), .instr_done_o(done), .illegal_o(ill), .state_o(st0)
    );

    mc_control_unit #(.ILLEGAL_TRAP(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .instr_op_i(op), .zero_i(zero), .mem_ready_i(rdy),
        .PCWrite_o(h_pcw), .PCWriteCond_o(h_pcwc), .IorD_o(h_iord), .MemRead_o(h_mr),
        .MemWrite_o(h_mw), .IRWrite_o(h_irw), .MemtoReg_o(h_m2r), .RegDst_o(h_rdst),
        .RegWrite_o(h_rw), .ALUSrcA_o(h_srca), .ALUSrcB_o(h_srcb), .ALU_op_o(h_aop),
        .PCSource_o(h_pcs), .instr_done_o(h_done), .illegal_o(h_ill), .state_o(st1)
    );

    function automatic logic is_legal(logic [5:0] o);
        return o inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
    endfunction

    // State walk of one instruction, from its fetch to its last cycle.
    function automatic void build_path(logic [5:0] o);
        case (o)
            6'b000000: path = '{0, 1, 6, 7};
            6'b100011: path = '{0, 1, 2, 3, 4};
            6'b101011: path = '{0, 1, 2, 5};
            6'b000100: path = '{0, 1, 8};
            6'b001000: path = '{0, 1, 9, 10};
            6'b000010: path = '{0, 1, 11};
            default:   path = '{0, 1};
        endcase
    endfunction

    // Expected output vector for a given state, ready, opcode and reset.
    function automatic logic [18:0] exp_out(int s, logic r, logic [5:0] o, logic rs);
        logic e_pcw, e_pcwc, e_iord, e_mr, e_mw, e_irw, e_m2r, e_rdst, e_rw, e_srca, e_done, e_ill;
        logic [1:0] e_srcb, e_pcs;
        logic [2:0] e_aop;
        {e_pcw, e_pcwc, e_iord, e_mr, e_mw, e_irw, e_m2r, e_rdst, e_rw, e_srca, e_done, e_ill} = '0;
        e_srcb = 2'b00; e_pcs = 2'b00; e_aop = 3'b000;
        if (rs) begin
            e_srcb = 2'b01;
        end else begin
            case (s)
                0:  begin e_mr = 1; e_srcb = 2'b01; e_irw = r; e_pcw = r; end
                1:  begin e_srcb = 2'b11; e_ill = !is_legal(o); end
                2:  begin e_srca = 1; e_srcb = 2'b10; end
                3:  begin e_mr = 1; e_iord = 1; end
                4:  begin e_rw = 1; e_m2r = 1; e_done = 1; end
                5:  begin e_mw = 1; e_iord = 1; e_done = r; end
                6:  begin e_srca = 1; e_aop = 3'b010; end
                7:  begin e_rw = 1; e_rdst = 1; e_done = 1; end
                8:  begin e_srca = 1; e_aop = 3'b001; e_pcwc = 1; e_pcs = 2'b01; e_done = 1; end
                9:  begin e_srca = 1; e_srcb = 2'b10; end
                10: begin e_rw = 1; e_done = 1; end
                11: begin e_pcw = 1; e_pcs = 2'b10; e_done = 1; end
                default: ;
            endcase
        end
        return {e_pcw, e_pcwc, e_iord, e_mr, e_mw, e_irw, e_m2r, e_rdst, e_rw, e_srca,
                e_srcb, e_aop, e_pcs, e_done, e_ill};
    endfunction

    // Quiet reset used between scenarios; leaves both FSMs in FETCH.
    task automatic do_reset();
        @(negedge clk); rst = 1'b1; rdy = 1'b0;
        @(negedge clk); rst = 1'b0;
    endtask

    // Drives one instruction through dut0, checking state and outputs each cycle.
    task automatic run_instr(input logic [5:0] iop, input logic iz, input int stall_prob,
                             input int stall_st, input int stall_n, output int cycles,
                             output int done_at, output int done_cnt, output int ill_cnt);
        int idx;
        int stalled;
        int s;
        logic [18:0] e;
        build_path(iop);
        idx = 0; cycles = 0; done_at = 0; done_cnt = 0; ill_cnt = 0; stalled = 0;
        while (idx < path.size() && cycles < 100) begin
            @(negedge clk);
            s = path[idx];
            rst = 1'b0; op = iop; zero = iz;
            if (s == stall_st && stalled < stall_n) begin
                rdy = 1'b0; stalled++;
            end else begin
                rdy = ($urandom_range(0, 99) >= stall_prob);
            end
            #1;
            cycles++;
            total++;
            if (st0 !== s[3:0]) begin
                bad++;
                $display("FAIL state op=%b cyc=%0d: got %0d want %0d", iop, cycles, st0, s);
            end
            e = exp_out(s, rdy, iop, 1'b0);
            total++;
            if (obs0 !== e) begin
                bad++;
                $display("FAIL outputs op=%b st=%0d cyc=%0d: got %b want %b", iop, s, cycles, obs0, e);
            end
            if (done === 1'b1) begin done_cnt++; done_at = cycles; end
            if (ill === 1'b1) ill_cnt++;
            if (!((s == 0 || s == 3 || s == 5) && !rdy)) idx++;
        end
        total++;
        if (idx < path.size()) begin
            bad++;
            $display("FAIL timeout op=%b: got step %0d want %0d", iop, idx, path.size());
        end
    endtask

    task automatic test_reset();
        logic [18:0] e;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            rst = 1'b1; rdy = 1'b1; op = 6'($urandom_range(0, 63)); zero = 1'($urandom);
            #1;
            e = exp_out(0, 1'b1, op, 1'b1);
            total++;
            if (obs0 !== e) begin
                bad++; $display("FAIL reset_outputs: got %b want %b", obs0, e);
            end
        end
        @(negedge clk); rst = 1'b0; rdy = 1'b0; op = 6'b000000; #1;
        total++;
        if (st0 !== 4'd0 || st1 !== 4'd0) begin
            bad++; $display("FAIL reset_state: got %0d/%0d want 0/0", st0, st1);
        end
        e = exp_out(0, 1'b0, op, 1'b0);
        total++;
        if (obs0 !== e) begin
            bad++; $display("FAIL fetch_wait: got %b want %b", obs0, e);
        end
    endtask

    task automatic check_run(input string name, input int c, input int c_want,
                             input int dc, input int dc_want);
        total++;
        if (c !== c_want) begin
            bad++; $display("FAIL %s cycles: got %0d want %0d", name, c, c_want);
        end
        total++;
        if (dc !== dc_want) begin
            bad++; $display("FAIL %s done_pulses: got %0d want %0d", name, dc, dc_want);
        end
    endtask

    task automatic test_rtype();
        int c, da, dc, ic;
        do_reset();
        run_instr(6'b000000, 1'b0, 0, -1, 0, c, da, dc, ic);
        check_run("rtype", c, 4, dc, 1);
    endtask

    task automatic test_lw_stall();
        int c, da, dc, ic;
        do_reset();
        run_instr(6'b100011, 1'b0, 0, 3, 2, c, da, dc, ic);
        check_run("lw_stall", c, 7, dc, 1);
    endtask

    task automatic test_beq();
        int c, da, dc, ic;
        do_reset();
        run_instr(6'b000100, 1'b1, 0, -1, 0, c, da, dc, ic);
        check_run("beq_z1", c, 3, dc, 1);
        run_instr(6'b000100, 1'b0, 0, -1, 0, c, da, dc, ic);
        check_run("beq_z0", c, 3, dc, 1);
    endtask

    task automatic test_illegal();
        int c, da, dc, ic;
        do_reset();
        run_instr(6'b111111, 1'b0, 0, -1, 0, c, da, dc, ic);
        check_run("illegal", c, 2, dc, 0);
        total++;
        if (ic !== 1) begin
            bad++; $display("FAIL illegal_pulses: got %0d want 1", ic);
        end
        // dut0 must be back in FETCH; dut1 parked in HALT with everything low.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rdy = 1'($urandom); op = 6'($urandom_range(0, 63)); zero = 1'($urandom); #1;
            total++;
            if (st1 !== 4'd15 || obs1 !== 19'd0) begin
                bad++; $display("FAIL trap_halt: got st=%0d out=%b want st=15 out=0", st1, obs1);
            end
            if (i == 0) begin
                total++;
                if (st0 !== 4'd0) begin
                    bad++; $display("FAIL illegal_return: got %0d want 0", st0);
                end
            end
        end
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0; rdy = 1'b0; #1;
        total++;
        if (st1 !== 4'd0) begin
            bad++; $display("FAIL trap_reset: got %0d want 0", st1);
        end
    endtask

    task automatic test_sw_reset();
        int want[3] = '{0, 1, 2};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); rst = 1'b0; rdy = 1'b1; op = 6'b101011; #1;
            total++;
            if (st0 !== want[i][3:0]) begin
                bad++; $display("FAIL sw_walk: got %0d want %0d", st0, want[i]);
            end
        end
        @(negedge clk); rst = 1'b1; rdy = 1'b1; #1;
        total++;
        if (st0 !== 4'd5 || mw !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL sw_reset_mwr: got st=%0d mw=%b done=%b want st=5 mw=0 done=0",
                            st0, mw, done);
        end
        @(negedge clk); rst = 1'b0; rdy = 1'b0; #1;
        total++;
        if (st0 !== 4'd0 || done !== 1'b0) begin
            bad++; $display("FAIL sw_reset_after: got st=%0d done=%b want st=0 done=0", st0, done);
        end
    endtask

    task automatic test_back_to_back();
        int c1, d1, dc1, ic1, c2, d2, dc2, ic2;
        do_reset();
        run_instr(6'b000010, 1'b0, 0, -1, 0, c1, d1, dc1, ic1);
        run_instr(6'b001000, 1'b0, 0, -1, 0, c2, d2, dc2, ic2);
        check_run("b2b_j", c1, 3, dc1, 1);
        check_run("b2b_addi", c2, 4, dc2, 1);
        total++;
        if (d1 !== 3 || c1 + d2 !== 7) begin
            bad++; $display("FAIL b2b_done_cycles: got %0d,%0d want 3,7", d1, c1 + d2);
        end
    endtask

    task automatic test_random();
        logic [5:0] ops[6] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
        logic [5:0] o;
        int c, da, dc, ic, k;
        do_reset();
        for (int n = 0; n < 40; n++) begin
            k = $urandom_range(0, 6);
            if (k < 6) o = ops[k];
            else begin
                o = 6'($urandom_range(0, 63));
                while (is_legal(o)) o = 6'($urandom_range(0, 63));
            end
            run_instr(o, 1'($urandom), 30, -1, 0, c, da, dc, ic);
            total++;
            if (dc !== (is_legal(o) ? 1 : 0) || ic !== (is_legal(o) ? 0 : 1)) begin
                bad++; $display("FAIL random_pulses op=%b: got done=%0d ill=%0d", o, dc, ic);
            end
        end
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b0; op = 6'b000000; zero = 1'b0;
        test_reset();
        test_rtype();
        test_lw_stall();
        test_beq();
        test_illegal();
        test_sw_reset();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
